// File: rtl/blink_rate_controller_if.sv
// Button, beat and command bundle between the front panel and the blinkers.
// master drives buttons and beat; slave is the rate controller.
interface blink_rate_controller_if #(
  parameter int EXP_W = 3
);
  logic             beat;
  logic             btn_select;
  logic             btn_slower;
  logic             btn_faster;
  logic             shift_left1;
  logic             shift_right1;
  logic             shift_left2;
  logic             shift_right2;
  logic [1:0]       edit_sel;
  logic [EXP_W-1:0] exp1;
  logic [EXP_W-1:0] exp2;

  modport master (
    output beat, btn_select, btn_slower, btn_faster,
    input  shift_left1, shift_right1, shift_left2, shift_right2,
    input  edit_sel, exp1, exp2
  );

  modport slave (
    input  beat, btn_select, btn_slower, btn_faster,
    output shift_left1, shift_right1, shift_left2, shift_right2,
    output edit_sel, exp1, exp2
  );
endinterface

// File: rtl/blink_rate_controller.sv
// Debounced three-button front end that selects a blinker and
// issues saturating period shift commands to it.
module blink_rate_controller #(
  parameter int DEBOUNCE_BEATS = 2,
  parameter int IDLE_BEATS     = 64,
  parameter int EXP_W          = 3,
  parameter int DEFAULT_EXP    = 5,
  parameter int MIN_EXP        = 1,
  parameter int MAX_EXP        = 7
) (
  input logic clk,
  input logic reset,
  blink_rate_controller_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE_BEATS + 1);
  localparam int ID_W = $clog2(IDLE_BEATS);

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    EDIT1  = 2'd1,
    EDIT2  = 2'd2
  } state_t;

  logic [2:0]            raw;
  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [2:0]            deb;
  logic [2:0]            deb_d;
  logic [2:0][DB_W-1:0]  cnt;
  logic [2:0]            ev;
  logic                  cmd_slow;
  logic                  cmd_fast;

  state_t                state_q;
  state_t                state_d;
  logic [ID_W-1:0]       idle_q;
  logic [ID_W-1:0]       idle_d;
  logic [EXP_W-1:0]      exp1_q;
  logic [EXP_W-1:0]      exp1_d;
  logic [EXP_W-1:0]      exp2_q;
  logic [EXP_W-1:0]      exp2_d;
  logic [3:0]            shift_q;
  logic [3:0]            shift_d;

  // bit 0 select, bit 1 slower, bit 2 faster
  assign raw = {bus.btn_faster, bus.btn_slower, bus.btn_select};

  // Two-flop synchronizers and beat-paced debouncers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (bus.beat) begin
          if (cnt[i] == DB_W'(DEBOUNCE_BEATS - 1)) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // A press is the rising edge of the debounced level
  assign ev = deb & ~deb_d;

  // Select dominates; opposing commands cancel each other
  assign cmd_slow = ev[1] & ~ev[2] & ~ev[0];
  assign cmd_fast = ev[2] & ~ev[1] & ~ev[0];

  // Edit-target state, idle timer, exponents and shift pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCKED;
      idle_q  <= '0;
      exp1_q  <= EXP_W'(DEFAULT_EXP);
      exp2_q  <= EXP_W'(DEFAULT_EXP);
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      exp1_q  <= exp1_d;
      exp2_q  <= exp2_d;
      shift_q <= shift_d;
    end
  end

  // Next state, idle timeout and saturating commands
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    exp1_d  = exp1_q;
    exp2_d  = exp2_q;
    shift_d = '0;
    if (ev[0]) begin
      idle_d = '0;
      unique case (state_q)
        LOCKED:  state_d = EDIT1;
        EDIT1:   state_d = EDIT2;
        default: state_d = LOCKED;
      endcase
    end else if (state_q != LOCKED) begin
      if (cmd_slow || cmd_fast) begin
        idle_d = '0;
      end else if (bus.beat) begin
        if (idle_q == ID_W'(IDLE_BEATS - 1)) begin
          state_d = LOCKED;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      if (state_q == EDIT1) begin
        if (cmd_slow && exp1_q < EXP_W'(MAX_EXP)) begin
          shift_d[3] = 1'b1;
          exp1_d     = exp1_q + 1'b1;
        end else if (cmd_fast && exp1_q > EXP_W'(MIN_EXP)) begin
          shift_d[2] = 1'b1;
          exp1_d     = exp1_q - 1'b1;
        end
      end else begin
        if (cmd_slow && exp2_q < EXP_W'(MAX_EXP)) begin
          shift_d[1] = 1'b1;
          exp2_d     = exp2_q + 1'b1;
        end else if (cmd_fast && exp2_q > EXP_W'(MIN_EXP)) begin
          shift_d[0] = 1'b1;
          exp2_d     = exp2_q - 1'b1;
        end
      end
    end
  end

  assign bus.shift_left1  = shift_q[3];
  assign bus.shift_right1 = shift_q[2];
  assign bus.shift_left2  = shift_q[1];
  assign bus.shift_right2 = shift_q[0];
  assign bus.edit_sel     = state_q;
  assign bus.exp1         = exp1_q;
  assign bus.exp2         = exp2_q;
endmodule

// File: tb/tb_blink_rate_controller.sv
// Directed bench for blink_rate_controller: beat every 10 clk,
// button presses, saturation, glitch/bounce, idle timeout, reset.
module tb_blink_rate_controller;
  logic clk;
  logic reset;
  logic beat_en;
  int   vectors;
  int   miscompares;
  int   pl1, pr1, pl2, pr2, multi;

  blink_rate_controller_if #(.EXP_W(3)) bus ();

  blink_rate_controller #(
    .DEBOUNCE_BEATS(2),
    .IDLE_BEATS(64),
    .EXP_W(3),
    .DEFAULT_EXP(5),
    .MIN_EXP(1),
    .MAX_EXP(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk beat every 10 clk while enabled
  initial begin
    int bc;
    bc = 0;
    bus.beat = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bc == 9) begin
        bc = 0;
        bus.beat = beat_en;
      end else begin
        bc++;
        bus.beat = 1'b0;
      end
    end
  end

  // Tally pulse cycles and any cycle with more than one shift high
  initial begin
    pl1 = 0; pr1 = 0; pl2 = 0; pr2 = 0; multi = 0;
    forever begin
      @(negedge clk);
      pl1 += int'(bus.shift_left1);
      pr1 += int'(bus.shift_right1);
      pl2 += int'(bus.shift_left2);
      pr2 += int'(bus.shift_right2);
      if (int'(bus.shift_left1) + int'(bus.shift_right1) +
          int'(bus.shift_left2) + int'(bus.shift_right2) > 1)
        multi++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_select = v;
      1: bus.btn_slower = v;
      default: bus.btn_faster = v;
    endcase
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    wait_clk(60);
    set_btn(b, 1'b0);
    wait_clk(60);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
  endtask

  initial begin
    int nb;
    int t;
    vectors = 0;
    miscompares = 0;
    beat_en = 1'b1;
    bus.btn_select = 1'b0;
    bus.btn_slower = 1'b0;
    bus.btn_faster = 1'b0;
    do_reset();
    wait_clk(100);
    @(negedge clk);
    check("rst_edit_sel", int'(bus.edit_sel), 0);
    check("rst_exp1", int'(bus.exp1), 5);
    check("rst_exp2", int'(bus.exp2), 5);
    check("rst_pulses", pl1 + pr1 + pl2 + pr2, 0);

    // Slower held in LOCKED is discarded
    set_btn(1, 1'b1);
    wait_clk(300);
    set_btn(1, 1'b0);
    wait_clk(60);
    @(negedge clk);
    check("locked_pulses", pl1 + pr1 + pl2 + pr2, 0);
    check("locked_exp1", int'(bus.exp1), 5);
    check("locked_exp2", int'(bus.exp2), 5);

    // EDIT1: two slower presses, third saturates
    press(0);
    check("sel_edit1", int'(bus.edit_sel), 1);
    press(1);
    check("slow1_exp1", int'(bus.exp1), 6);
    press(1);
    check("slow2_pl1", pl1, 2);
    check("slow2_exp1", int'(bus.exp1), 7);
    press(1);
    check("slow3_pl1", pl1, 2);
    check("slow3_exp1", int'(bus.exp1), 7);

    // EDIT2: four faster presses reach MIN, fifth dropped
    press(0);
    check("sel_edit2", int'(bus.edit_sel), 2);
    for (int k = 0; k < 4; k++) press(2);
    check("fast4_pr2", pr2, 4);
    check("fast4_exp2", int'(bus.exp2), 1);
    press(2);
    check("fast5_pr2", pr2, 4);
    check("fast5_exp2", int'(bus.exp2), 1);
    press(0);
    check("sel_locked", int'(bus.edit_sel), 0);
    check("no_pr1_pl2", pr1 + pl2, 0);

    // Glitch high for one beat only
    set_btn(0, 1'b1);
    wait_clk(10);
    set_btn(0, 1'b0);
    wait_clk(60);
    check("glitch", int'(bus.edit_sel), 0);

    // Bounce train then steady high gives one event
    for (int k = 0; k < 30; k++) begin
      set_btn(0, k[0] ? 1'b0 : 1'b1);
      wait_clk(1);
    end
    set_btn(0, 1'b1);
    wait_clk(60);
    set_btn(0, 1'b0);
    wait_clk(60);
    check("bounce_one", int'(bus.edit_sel), 1);
    press(0);
    press(0);
    check("back_locked", int'(bus.edit_sel), 0);

    // Idle timeout: 64 beats after entry returns to LOCKED
    set_btn(0, 1'b1);
    t = 0;
    @(negedge clk);
    while (bus.edit_sel != 2'd1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_entry", int'(bus.edit_sel), 1);
    set_btn(0, 1'b0);
    nb = 0;
    t = 0;
    while (nb < 63 && t < 1000) begin
      @(negedge clk);
      t++;
      if (bus.beat) nb++;
    end
    check("idle_63", int'(bus.edit_sel), 1);
    nb = 0;
    t = 0;
    while (nb < 1 && t < 20) begin
      @(negedge clk);
      t++;
      if (bus.beat) nb++;
    end
    check("idle_64_pre", int'(bus.edit_sel), 1);
    @(negedge clk);
    check("idle_64_post", int'(bus.edit_sel), 0);
    wait_clk(40);

    // Slower+faster together dropped; single faster on flash1
    press(0);
    check("edit1_again", int'(bus.edit_sel), 1);
    bus.btn_slower = 1'b1;
    bus.btn_faster = 1'b1;
    wait_clk(60);
    bus.btn_slower = 1'b0;
    bus.btn_faster = 1'b0;
    wait_clk(60);
    check("both_pulses", pl1 + pr1 + pl2 + pr2, 6);
    check("both_exp1", int'(bus.exp1), 7);
    press(2);
    check("fast1_pr1", pr1, 1);
    check("fast1_exp1", int'(bus.exp1), 6);

    // Reset returns state and exponents to defaults
    do_reset();
    @(negedge clk);
    check("rst2_edit_sel", int'(bus.edit_sel), 0);
    check("rst2_exp1", int'(bus.exp1), 5);
    check("rst2_exp2", int'(bus.exp2), 5);

    // Frozen beat: no debounce progress until beats resume
    beat_en = 1'b0;
    wait_clk(12);
    set_btn(0, 1'b1);
    wait_clk(100);
    check("freeze", int'(bus.edit_sel), 0);
    beat_en = 1'b1;
    wait_clk(60);
    check("unfreeze", int'(bus.edit_sel), 1);
    set_btn(0, 1'b0);
    wait_clk(60);

    check("one_hot", multi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
